// File: rtl/datapath_pkg.sv
// datapath_pkg: shared state encoding and counter sizing for the serial adder controller
package datapath_pkg;
  typedef enum logic [1:0] {SA_IDLE = 2'd0, SA_SHIFT = 2'd1, SA_DONE = 2'd2} sa_state_e;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  output logic out,
  output logic cout,
  input  logic num1,
  input  logic num2,
  input  logic cin
);
  assign out  = num1 ^ num2 ^ cin;
  assign cout = (num1 & num2) | (cin & (num1 ^ num2));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, one full_adder reused LSB first with start/busy/done framing
module serial_add_ctrl
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = cnt_w(WIDTH);
  sa_state_e        state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic             fa_out, fa_cout, last;
  full_adder u_fa (.out(fa_out), .cout(fa_cout), .num1(a_q[0]), .num2(b_q[0]), .cin(carry_q));
  assign last     = cnt_q == CW'(WIDTH - 1);
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SA_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q == SA_SHIFT) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= WIDTH'({fa_out, sum_q} >> 1);
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        state_q <= SA_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        cout_q  <= fa_cout;
        // carry_q is the carry into the MSB on this edge
        ovf_q   <= carry_q ^ fa_cout;
      end
    end else if (start) begin
      state_q <= SA_SHIFT;
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= SA_IDLE;
      done_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       busy, done, cout, overflow;
  logic [7:0] exp_sum = '0;
  logic       exp_cout = 1'b0, exp_ovf = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c, input bit hold);
    logic [8:0] t;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    start = 1'b1;
    a = x;
    b = y;
    cin = c;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("no_done_in_shift", 32'(done), 32'd0);
      if (!hold || i == 7) start = 1'b0;
      if (hold) begin
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
      end
    end
    exp_sum  = t[7:0];
    exp_cout = t[8];
    exp_ovf  = (x[7] == y[7]) && (exp_sum[7] != x[7]);
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("cout", 32'(cout), 32'(exp_cout));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sum_hold", 32'(sum), 32'(exp_sum));
      chk("idle_cout_hold", 32'(cout), 32'(exp_cout));
      chk("idle_ovf_hold", 32'(overflow), 32'(exp_ovf));
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    idle(2);
    run_op(8'h55, 8'hAA, 1'b0, 1'b0);
    idle(2);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    idle(1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    idle(1);
    run_op(8'h80, 8'h80, 1'b1, 1'b1);
    idle(2);
    run_op(8'h0F, 8'hF0, 1'b1, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);
    idle(2);
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    idle(10);
    run_op(8'h03, 8'h04, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
